// File: rtl/string_match_ctrl.sv
// rtl/string_match_ctrl.sv - pattern-slot store, packet sequencer and hit collector for the comparator bank
module string_match_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int DRAIN_CYCLES = 6,
  parameter int CNT_W        = 16,
  localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_en,
  input  logic [SLOT_W-1:0]         cfg_slot,
  input  logic [135:0]              cfg_string,
  input  logic [4:0]                cfg_strlen,
  input  logic                      cfg_slot_en,
  output logic                      cfg_busy,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      in_ready,
  output logic [NUM_SLOTS*136-1:0]  cmp_string,
  output logic [NUM_SLOTS*5-1:0]    cmp_strlen,
  output logic                      cmp_clear,
  input  logic [NUM_SLOTS-1:0]      cmp_match,
  output logic                      flag_valid,
  output logic [NUM_SLOTS-1:0]      flag_hits,
  output logic [SLOT_W-1:0]         flag_first,
  input  logic                      flag_ack,
  output logic [CNT_W-1:0]          flag_count,
  output logic                      proto_err
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, REPORT, CLEAR} state_t;

  state_t               state;
  logic [135:0]         slot_str [NUM_SLOTS];
  logic [4:0]           slot_len [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en;
  logic [DC_W-1:0]      drain_cnt;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [SLOT_W-1:0]    first_r;

  logic                 beat;
  logic [NUM_SLOTS-1:0] hit_new;
  logic [NUM_SLOTS-1:0] hit_next;
  logic [SLOT_W-1:0]    first_idx;

  // Status outputs decode the state register only, so no input reaches them combinationally
  assign in_ready   = (state == IDLE) || (state == SCAN);
  assign cfg_busy   = (state != IDLE);
  assign flag_valid = (state == REPORT);
  assign cmp_clear  = (state == CLEAR);
  assign flag_hits  = hit_vec;
  assign flag_first = first_r;

  assign beat     = in_valid & in_ready;
  assign hit_new  = cmp_match & slot_en;
  assign hit_next = hit_vec | hit_new;

  // Flatten slot registers onto the comparator buses, slot0 in the LSBs
  always_comb begin
    cmp_string = '0;
    cmp_strlen = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      cmp_string[s*136 +: 136] = slot_str[s];
      cmp_strlen[s*5 +: 5]     = slot_len[s];
    end
  end

  // Lowest slot index among this cycle's enabled matches
  always_comb begin
    first_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_new[i]) first_idx = SLOT_W'(i);
    end
  end

  // Packet sequencer, slot programming and hit collection
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot_en    <= '0;
      drain_cnt  <= '0;
      hit_vec    <= '0;
      first_r    <= '0;
      flag_count <= '0;
      proto_err  <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_str[s] <= '0;
        slot_len[s] <= '0;
      end
    end else begin
      if (state == IDLE && cfg_wr_en) begin
        slot_str[cfg_slot] <= cfg_string;
        slot_len[cfg_slot] <= (cfg_strlen > 5'd16) ? 5'd16 : cfg_strlen;
        slot_en[cfg_slot]  <= cfg_slot_en;
      end

      // Hits accumulate while beats are in flight and while the pipeline drains
      if (state == SCAN || state == DRAIN) begin
        hit_vec <= hit_next;
        if (hit_vec == '0 && hit_new != '0) first_r <= first_idx;
      end

      case (state)
        IDLE: begin
          if (beat) begin
            if (!in_sop) begin
              proto_err <= 1'b1;
            end else if (in_eop) begin
              state     <= DRAIN;
              drain_cnt <= DC_W'(DRAIN_CYCLES - 1);
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (beat && in_eop) begin
            state     <= DRAIN;
            drain_cnt <= DC_W'(DRAIN_CYCLES - 1);
          end else if (beat && in_sop) begin
            // A new packet started before the old one ended: drop what was collected
            hit_vec   <= '0;
            first_r   <= '0;
            proto_err <= 1'b1;
            state     <= CLEAR;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= (hit_next != '0) ? REPORT : CLEAR;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        REPORT: begin
          if (flag_ack) begin
            state <= CLEAR;
            if (flag_count != {CNT_W{1'b1}}) flag_count <= flag_count + 1'b1;
          end
        end
        CLEAR: begin
          hit_vec <= '0;
          first_r <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
